// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Iterative multiply/divide unit with HI/LO result registers.
//            MULT/MULTU use a one-bit-per-cycle shift-add multiplier and
//            DIV/DIVU use a one-bit-per-cycle restoring divider. Signed
//            operations iterate on magnitudes and fix the sign on the final
//            step. MTHI/MTLO write a result register in a single cycle.
//            Optional feature macro: MDU_DIV_EN (divider, DIV state and
//            div_by_zero); when undefined, divide opcodes are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [CW-1:0] c_last_cnt = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    // State encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MDU_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif

    // Operation codes
    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
`endif
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    // Working registers: multiply = {partial-product high, multiplier/low},
    // divide = {partial remainder, dividend/quotient}.
    logic [WIDTH-1:0] whi_q,   whi_d;
    logic [WIDTH-1:0] wlo_q,   wlo_d;
    // Multiplicand (multiply) or divisor magnitude (divide)
    logic [WIDTH-1:0] opnd_q,  opnd_d;
    // Negate the product / quotient on the final step
    logic             neg_lo_q, neg_lo_d;
`ifdef MDU_DIV_EN
    // Negate the remainder on the final step
    logic             neg_hi_q, neg_hi_d;
    logic             dbz_q,    dbz_d;
`endif
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic             done_q,  done_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_op_signed;
    logic                 w_last_step;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
`ifdef MDU_DIV_EN
    logic [WIDTH:0]       w_div_trial;
    logic                 w_div_ok;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
`endif

    // Request decode, operand magnitudes and one iteration of each datapath
    always_comb begin
        w_accept    = start && (state_q == S_IDLE);
        // MULT (001) and DIV (011) are the signed variants
        w_op_signed = op[0];
        w_last_step = (cnt_q == c_last_cnt);
        w_mag_a     = (w_op_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        w_mag_b     = (w_op_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

        // Shift-add: conditionally add the multiplicand to the high half,
        // then shift the whole product right by one (carry enters the top).
        w_mul_sum   = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, opnd_q} : '0);
        w_prod_next = {w_mul_sum, wlo_q[WIDTH-1:1]};
        w_prod_fix  = neg_lo_q ? (~w_prod_next + 1'b1) : w_prod_next;

`ifdef MDU_DIV_EN
        // Restoring step: shift next dividend bit into the remainder and
        // subtract the divisor; a clear borrow bit means the trial fits.
        w_div_trial = {whi_q, wlo_q[WIDTH-1]} - {1'b0, opnd_q};
        w_div_ok    = ~w_div_trial[WIDTH];
        w_rem_next  = w_div_ok ? w_div_trial[WIDTH-1:0]
                               : {whi_q[WIDTH-2:0], wlo_q[WIDTH-1]};
        w_quo_next  = {wlo_q[WIDTH-2:0], w_div_ok};
        w_quo_fix   = neg_lo_q ? (~w_quo_next + 1'b1) : w_quo_next;
        w_rem_fix   = neg_hi_q ? (~w_rem_next + 1'b1) : w_rem_next;
`endif
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            whi_q    <= '0;
            wlo_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
`ifdef MDU_DIV_EN
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
`endif
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            whi_q    <= whi_d;
            wlo_q    <= wlo_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
`ifdef MDU_DIV_EN
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
`endif
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: leave IDLE on an accepted iterative op, return on
    // the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if ((op == OP_MULTU) || (op == OP_MULT)) begin
                        state_d = S_MUL;
                    end
`ifdef MDU_DIV_EN
                    else if (((op == OP_DIVU) || (op == OP_DIV)) && (B != '0)) begin
                        state_d = S_DIV;
                    end
`endif
                end
            end
            S_MUL: begin
                if (w_last_step) begin
                    state_d = S_IDLE;
                end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                if (w_last_step) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates: load operands on accept, iterate, commit on the
    // final step; single-cycle ops write HI/LO directly
    always_comb begin
        cnt_d    = cnt_q;
        whi_d    = whi_q;
        wlo_d    = wlo_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
`ifdef MDU_DIV_EN
        neg_hi_d = neg_hi_q;
        dbz_d    = 1'b0;
`endif
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_MULTU, OP_MULT: begin
                            cnt_d    = '0;
                            whi_d    = '0;
                            wlo_d    = w_mag_b;
                            opnd_d   = w_mag_a;
                            neg_lo_d = w_op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        end
`ifdef MDU_DIV_EN
                        OP_DIVU, OP_DIV: begin
                            if (B == '0) begin
                                // No iteration: raw dividend to HI, all ones to LO
                                hi_d   = A;
                                lo_d   = '1;
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                cnt_d    = '0;
                                whi_d    = '0;
                                wlo_d    = w_mag_a;
                                opnd_d   = w_mag_b;
                                neg_lo_d = w_op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_hi_d = w_op_signed & A[WIDTH-1];
                            end
                        end
`endif
                        OP_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + c_cnt_one;
                {whi_d, wlo_d} = w_prod_next;
                if (w_last_step) begin
                    cnt_d        = '0;
                    {hi_d, lo_d} = w_prod_fix;
                    done_d       = 1'b1;
                end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                cnt_d = cnt_q + c_cnt_one;
                whi_d = w_rem_next;
                wlo_d = w_quo_next;
                if (w_last_step) begin
                    cnt_d  = '0;
                    lo_d   = w_quo_fix;
                    hi_d   = w_rem_fix;
                    done_d = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Outputs: busy follows the state, results come straight from HI/LO
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
`ifdef MDU_DIV_EN
        div_by_zero = dbz_q;
`else
        div_by_zero = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Parametrised iterative multiply/divide unit with HI/LO result registers. It sits beside the combinational ALU in the MIPS-Lite datapath and adds MULT/MULTU/DIV/DIVU/MTHI/MTLO. A start/busy/done handshake lets the control unit stall the pipeline while an operation runs. The HI/LO registers drive MFHI/MFLO reads directly.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Must be ≥ 4.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request. Sampled only when `busy` = 0.
- `op` in 3: operation code, sampled with `start`.
- `A` in WIDTH: operand A (multiplicand / dividend / MTHI-MTLO source).
- `B` in WIDTH: operand B (multiplier / divisor).
- `busy` out 1: iterative operation in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid in the same cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `div_by_zero` out 1: one-cycle pulse, coincident with `done`, for a divide with B = 0.

## Operation
- `op` encoding:
  - 3'b000 MULTU
  - 3'b001 MULT
  - 3'b010 DIVU
  - 3'b011 DIV
  - 3'b100 MTHI (`hi` ← A)
  - 3'b101 MTLO (`lo` ← A)
  - 3'b110/3'b111: no effect, no `done`.
- States:
  - IDLE → MUL on accepted multiply.
  - IDLE → DIV on accepted divide with B ≠ 0.
  - MUL/DIV → IDLE when the iteration counter reaches WIDTH−1.
- Accept: `start` = 1 and `busy` = 0. A `start` during `busy` is ignored; it is not queued.
- Signed ops: operands are converted to magnitudes at accept. The iteration is unsigned, and the sign is fixed on the final step.
- Multiply: shift-add, one bit per cycle. The 2·WIDTH-bit product goes {`hi`,`lo`}.
- Divide: restoring, one quotient bit per cycle.
  - Quotient → `lo`, remainder → `hi`.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV of most-negative by −1: `lo` = most-negative (wraps), `hi` = 0.
- Divide by zero: no iteration. `lo` = all ones, `hi` = A, and `done` and `div_by_zero` pulse.
- MTHI/MTLO: single-cycle write; the other register is unchanged; `done` pulses.
- `hi`/`lo` hold their value between operations and are updated only on the `done` cycle. Intermediate results are kept in internal working registers.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, state IDLE, counter 0.
- Iterative op accepted at edge k:
  - `busy` = 1 after edge k through edge k+WIDTH−1.
  - At edge k+WIDTH: `busy` = 0, `done` = 1, `hi`/`lo` updated.
  - Latency is WIDTH cycles.
- A new `start` is accepted in the `done` cycle, because `busy` = 0 there (back-to-back operation).
- MTHI/MTLO/divide-by-zero accepted at edge k: registers written and `done` = 1 after edge k. `busy` never rises.
- `rst_n` = 0 mid-operation: aborts at the next edge. All outputs return to reset values; no `done`.
- `start` coincident with `rst_n` = 0: reset wins.

## Configuration
- `MDU_DIV_EN` defined: the divider datapath, DIV state and `div_by_zero` are compiled in.
- Not defined:
  - DIVU/DIV behave as unrecognised opcodes: no state change, no `done`.
  - `div_by_zero` is tied 0.
  - Multiply and MTHI/MTLO are unaffected.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 32 cycles `done`, `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for exactly 32 cycles.
- MULT A=0xFFFFFFFD (−3), B=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (−7), B=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU A=0x64, B=0 → next cycle `done`=`div_by_zero`=1, `lo`=0xFFFFFFFF, `hi`=0x64, `busy` never 1.
- MULTU 3×4 accepted, `start` with MTHI A=0x55 during `busy` → ignored; final `hi`=0, `lo`=12; then MTHI 0x55 in the `done` cycle → `hi`=0x55 next cycle.
- Start DIVU 100/7, assert `rst_n`=0 at cycle 10 → all outputs 0, no `done`. Rerun after reset → `lo`=14, `hi`=2.
